// File: rtl/jt12_timer_mmr_pkg.sv
// Shared register map and field positions for the YM2612 timer register front end.
package jt12_timer_mmr_pkg;

    localparam logic [7:0] REG_TIMA_HI = 8'h24;
    localparam logic [7:0] REG_TIMA_LO = 8'h25;
    localparam logic [7:0] REG_TIMB    = 8'h26;
    localparam logic [7:0] REG_TMODE   = 8'h27;

    // Bit positions inside register 0x27
    localparam int LOAD_A   = 0;
    localparam int LOAD_B   = 1;
    localparam int EN_A     = 2;
    localparam int EN_B     = 3;
    localparam int CLR_A    = 4;
    localparam int CLR_B    = 5;
    localparam int MODE_LSB = 6;

    localparam logic [1:0] CSM_MODE = 2'b10;

    function automatic logic is_timer_reg(input logic [7:0] r);
        return (r >= REG_TIMA_HI) && (r <= REG_TMODE);
    endfunction

endpackage

// File: rtl/jt12_busy_cnt.sv
// Write-busy counter: reloads on every data write, counts down on cen, busy while non-zero.
module jt12_busy_cnt #(
    parameter int BUSY_CNT = 32,
    parameter int BW       = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic load,
    output logic busy
);

    logic [BW-1:0] cnt_q, cnt_d;

    // A reload takes priority over a coincident cen decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = BW'(BUSY_CNT);
        else if (cen && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/jt12_timer_mmr.sv
// CPU register front end for the FM timer pair: decodes 0x24-0x27, busy, status byte, CSM key-on.
module jt12_timer_mmr
    import jt12_timer_mmr_pkg::*;
#(
    parameter int BUSY_CNT = 32,
    parameter int BW       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       zero,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       overflow_A,
    output logic [7:0] dout,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic [1:0] ch3_mode,
    output logic       csm_keyon,
    output logic       busy
);

    logic       wr, wr_edge, data_we, reg_we;
    logic       wr_q, lock_q, lock_d;
    logic [7:0] reg_num_q, reg_num_d;
    logic       part_q, part_d;
    logic [9:0] va_q, va_d;
    logic [7:0] vb_q, vb_d;
    logic [1:0] mode_q, mode_d;
    logic       ld_a_q, ld_a_d, ld_b_q, ld_b_d;
    logic       en_a_q, en_a_d, en_b_q, en_b_d;
    logic       clr_a_q, clr_a_d, clr_b_q, clr_b_d;
    logic [7:0] dout_q, dout_d;

    // lock_q keeps a strobe that was already held through reset from counting as a write.
    assign wr      = ~cs_n & ~wr_n;
    assign wr_edge = wr & ~wr_q & ~lock_q;
    assign data_we = wr_edge & addr[0];
    assign reg_we  = data_we & ~part_q & is_timer_reg(reg_num_q);
    assign lock_d  = lock_q & wr;

    always_comb begin
        reg_num_d = reg_num_q;
        part_d    = part_q;
        va_d      = va_q;
        vb_d      = vb_q;
        mode_d    = mode_q;
        ld_a_d    = ld_a_q;
        ld_b_d    = ld_b_q;
        en_a_d    = en_a_q;
        en_b_d    = en_b_q;
        clr_a_d   = 1'b0;
        clr_b_d   = 1'b0;
        dout_d    = {busy, 5'b0, flag_B, flag_A};
        if (wr_edge && !addr[0]) begin
            reg_num_d = din;
            part_d    = addr[1];
        end
        if (reg_we) begin
            case (reg_num_q)
                REG_TIMA_HI: va_d[9:2] = din;
                REG_TIMA_LO: va_d[1:0] = din[1:0];
                REG_TIMB:    vb_d      = din;
                default: begin
                    mode_d  = din[MODE_LSB +: 2];
                    clr_b_d = din[CLR_B];
                    clr_a_d = din[CLR_A];
                    en_b_d  = din[EN_B];
                    en_a_d  = din[EN_A];
                    ld_b_d  = din[LOAD_B];
                    ld_a_d  = din[LOAD_A];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            lock_q    <= 1'b1;
            reg_num_q <= 8'h00;
            part_q    <= 1'b0;
            va_q      <= '0;
            vb_q      <= '0;
            mode_q    <= '0;
            ld_a_q    <= 1'b0;
            ld_b_q    <= 1'b0;
            en_a_q    <= 1'b0;
            en_b_q    <= 1'b0;
            clr_a_q   <= 1'b0;
            clr_b_q   <= 1'b0;
            dout_q    <= '0;
        end else begin
            wr_q      <= wr;
            lock_q    <= lock_d;
            reg_num_q <= reg_num_d;
            part_q    <= part_d;
            va_q      <= va_d;
            vb_q      <= vb_d;
            mode_q    <= mode_d;
            ld_a_q    <= ld_a_d;
            ld_b_q    <= ld_b_d;
            en_a_q    <= en_a_d;
            en_b_q    <= en_b_d;
            clr_a_q   <= clr_a_d;
            clr_b_q   <= clr_b_d;
            dout_q    <= dout_d;
        end
    end

    jt12_busy_cnt #(
        .BUSY_CNT (BUSY_CNT),
        .BW       (BW)
    ) u_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .load  (data_we),
        .busy  (busy)
    );

    // Same qualifier the timer uses to raise flag_A, so key-on lines up with the overflow.
    assign csm_keyon = (mode_q == CSM_MODE) & cen & zero & ld_a_q & overflow_A;

    assign dout         = dout_q;
    assign value_A      = va_q;
    assign value_B      = vb_q;
    assign load_A       = ld_a_q;
    assign load_B       = ld_b_q;
    assign clr_flag_A   = clr_a_q;
    assign clr_flag_B   = clr_b_q;
    assign enable_irq_A = en_a_q;
    assign enable_irq_B = en_b_q;
    assign ch3_mode     = mode_q;

endmodule

// File: tb/tb_jt12_timer_mmr.sv
// Randomized and directed checks of jt12_timer_mmr against a cycle-level behavioural model.
module tb_jt12_timer_mmr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b1;
    logic       zero = 1'b0;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [1:0] addr = 2'b00;
    logic [7:0] din = 8'h00;
    logic       flag_A = 1'b0;
    logic       flag_B = 1'b0;
    logic       overflow_A = 1'b0;

    logic [7:0] dout;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, clr_flag_A, clr_flag_B;
    logic       enable_irq_A, enable_irq_B, csm_keyon, busy;
    logic [1:0] ch3_mode;

    jt12_timer_mmr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen          (cen),
        .zero         (zero),
        .cs_n         (cs_n),
        .wr_n         (wr_n),
        .addr         (addr),
        .din          (din),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .overflow_A   (overflow_A),
        .dout         (dout),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .ch3_mode     (ch3_mode),
        .csm_keyon    (csm_keyon),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int         m_cnt = 0;
    logic [7:0] m_reg = 8'h00;
    logic       m_part = 1'b0;
    logic [9:0] m_va = '0;
    logic [7:0] m_vb = '0;
    logic [7:0] m_ctl = '0;   // 0x27 image with the clear bits removed
    logic       m_clra = 1'b0, m_clrb = 1'b0;
    logic [7:0] m_dout = '0;
    logic       m_wr_prev = 1'b0;
    logic       m_armed = 1'b0;

    task automatic model_edge();
        logic wr, fire;
        if (!rst_n) begin
            m_cnt = 0; m_reg = 8'h00; m_part = 1'b0; m_va = '0; m_vb = '0;
            m_ctl = '0; m_clra = 1'b0; m_clrb = 1'b0; m_dout = '0;
            m_wr_prev = 1'b0; m_armed = 1'b0;
            return;
        end
        m_dout = {(m_cnt != 0), 5'b0, flag_B, flag_A};
        wr = !cs_n && !wr_n;
        fire = wr && !m_wr_prev && m_armed;
        if (!wr) m_armed = 1'b1;
        m_wr_prev = wr;
        m_clra = 1'b0;
        m_clrb = 1'b0;
        if (fire && !addr[0]) begin
            m_reg = din;
            m_part = addr[1];
        end
        if (fire && addr[0]) begin
            m_cnt = 32;
            if (!m_part) begin
                if (m_reg == 8'h24) m_va = {din, m_va[1:0]};
                else if (m_reg == 8'h25) m_va = {m_va[9:2], din[1:0]};
                else if (m_reg == 8'h26) m_vb = din;
                else if (m_reg == 8'h27) begin
                    m_ctl = din & 8'hCF;
                    m_clrb = din[5];
                    m_clra = din[4];
                end
            end
        end else if (cen && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end
    endtask

    task automatic cycle();
        logic exp_csm;
        @(posedge clk);
        model_edge();
        #1;
        exp_csm = (m_ctl[7:6] == 2'b10) && cen && zero && m_ctl[0] && overflow_A;
        chk("value_A", 32'(value_A), 32'(m_va));
        chk("value_B", 32'(value_B), 32'(m_vb));
        chk("ctl", 32'({ch3_mode, 2'b00, enable_irq_B, enable_irq_A, load_B, load_A}), 32'(m_ctl));
        chk("clr", 32'({clr_flag_B, clr_flag_A}), 32'({m_clrb, m_clra}));
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("csm_keyon", 32'(csm_keyon), 32'(exp_csm));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        cycle();
        cs_n = 1'b1; wr_n = 1'b1;
        cycle();
    endtask

    task automatic wr_reg(input logic [7:0] r, input logic [7:0] d);
        write(2'b00, r);
        write(2'b01, d);
    endtask

    initial begin
        int n;
        int pulses;

        // Reset
        rst_n = 1'b0;
        idle(2);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Timer A value across two registers, then busy length
        wr_reg(8'h24, 8'hFF);
        chk("va_hi", 32'(value_A), 32'h3FC);
        wr_reg(8'h25, 8'h03);
        chk("va_full", 32'(value_A), 32'h3FF);
        n = 0;
        while (busy && n < 100) begin
            cycle();
            n++;
        end
        // 32 cen ticks from the data edge; one of them falls inside the write's release cycle
        chk("busy_len", 32'(n), 32'd31);

        // Timer B and control register
        wr_reg(8'h26, 8'h80);
        chk("vb", 32'(value_B), 32'h80);
        write(2'b00, 8'h27);
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h3F;
        cycle();
        chk("clr_ab_hi", 32'({clr_flag_B, clr_flag_A}), 32'h3);
        cs_n = 1'b1; wr_n = 1'b1;
        cycle();
        chk("clr_ab_lo", 32'({clr_flag_B, clr_flag_A}), 32'h0);
        chk("ctl_3f", 32'({ch3_mode, enable_irq_B, enable_irq_A, load_B, load_A}), 32'h0F);

        // Part 1 address: data only touches busy
        idle(40);
        write(2'b10, 8'h24);
        write(2'b01, 8'h55);
        chk("part1_va", 32'(value_A), 32'h3FF);
        chk("part1_busy", 32'(busy), 32'h1);

        // CSM key-on only in mode 2'b10
        wr_reg(8'h27, 8'h81);
        cen = 1'b1; zero = 1'b1; overflow_A = 1'b1;
        cycle();
        chk("csm_on", 32'(csm_keyon), 32'h1);
        overflow_A = 1'b0;
        cycle();
        wr_reg(8'h27, 8'h41);
        overflow_A = 1'b1;
        cycle();
        chk("csm_off", 32'(csm_keyon), 32'h0);
        overflow_A = 1'b0; zero = 1'b0;

        // Long strobe performs one write
        write(2'b00, 8'h27);
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01; din = 8'h10;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (clr_flag_A) pulses++;
        end
        cs_n = 1'b1; wr_n = 1'b1;
        cycle();
        chk("long_strobe", 32'(pulses), 32'd1);

        // Status byte with flags
        idle(40);
        flag_A = 1'b1; flag_B = 1'b1;
        write(2'b01, 8'h00);
        chk("dout_busy", 32'(dout), 32'h83);
        idle(40);
        chk("dout_idle", 32'(dout), 32'h03);
        flag_A = 1'b0; flag_B = 1'b0;

        // Reset while busy
        write(2'b01, 8'h00);
        rst_n = 1'b0;
        cycle();
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_dout", 32'(dout), 32'h0);

        // Strobe held across reset is not a new write
        cs_n = 1'b0; wr_n = 1'b0; addr = 2'b01;
        cycle();
        rst_n = 1'b1;
        idle(3);
        chk("rst_mid_strobe", 32'(busy), 32'h0);
        cs_n = 1'b1; wr_n = 1'b1;
        idle(2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cen = ($urandom_range(0, 3) != 0);
            zero = $urandom_range(0, 1);
            cs_n = ($urandom_range(0, 2) == 0);
            wr_n = $urandom_range(0, 1);
            addr = 2'($urandom_range(0, 3));
            if (addr[1] && $urandom_range(0, 3) != 0) addr[1] = 1'b0;
            if (!addr[0] && $urandom_range(0, 4) != 0)
                din = 8'h24 + 8'($urandom_range(0, 3));
            else
                din = 8'($urandom);
            flag_A = $urandom_range(0, 1);
            flag_B = $urandom_range(0, 1);
            overflow_A = $urandom_range(0, 1);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt12_timer_mmr.md
Name: jt12_timer_mmr

Overview:
- CPU-facing register front end for the FM timer pair.
- Decodes YM2612-style address/data writes to part-I registers 0x24–0x27 and drives the timer block's start values, load enables, flag-clear pulses and IRQ enables.
- Generates the busy status, the registered status byte, and the CSM key-on pulse on a channel-3 Timer A overflow.
- Sits directly upstream of the timer pair; also consumes its flags and the Timer A overflow.

Parameters:
BUSY_CNT, 32, number of cen ticks busy stays high after a data write
BW, 6, busy counter width; must satisfy 2^BW > BUSY_CNT

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
cen  in  1  clock enable shared with the timers
zero  in  1  timer tick qualifier, same signal the timers use
cs_n  in  1  chip select, active low
wr_n  in  1  write strobe, active low
addr  in  2  addr[0]: 0 = address, 1 = data; addr[1]: part select
din  in  8  CPU write data
flag_A  in  1  Timer A flag from timers
flag_B  in  1  Timer B flag from timers
overflow_A  in  1  Timer A overflow (combinational from timer)
dout  out  8  status byte {busy, 5'b0, flag_B, flag_A}
value_A  out  10  Timer A start value
value_B  out  8  Timer B start value
load_A  out  1  Timer A run/load level
load_B  out  1  Timer B run/load level
clr_flag_A  out  1  one-clk clear pulse
clr_flag_B  out  1  one-clk clear pulse
enable_irq_A  out  1  Timer A IRQ enable
enable_irq_B  out  1  Timer B IRQ enable
ch3_mode  out  2  reg 0x27 bits 7:6
csm_keyon  out  1  one-clk CSM key-on pulse
busy  out  1  write busy

Behaviour:
- Reset (rst_n low at a clk edge): every output is 0; latched register number is 0x00; latched part is 0; busy counter is 0; stored write-strobe history is 0.
- Write strobe: wr = !cs_n & !wr_n. A write acts only on its first asserted cycle (rising edge of wr vs. its registered value). Holding the strobe low for many cycles performs exactly one write. Writes are not gated by cen.
- Address write (addr[0]=0): latch reg_num <= din and part <= addr[1].
- Data write (addr[0]=1):
  - Always restarts busy: counter <= BUSY_CNT and busy=1, even if busy was already high. Writes during busy are accepted.
  - Registers are updated only if the latched part is 0 and reg_num is 0x24..0x27. Any other target changes only busy.
  - The addr[1] of the data phase is ignored.
- Register map:
  - 0x24: value_A[9:2] <= din.
  - 0x25: value_A[1:0] <= din[1:0].
  - 0x26: value_B <= din.
  - 0x27:
    - ch3_mode <= din[7:6]
    - clr_flag_B pulses if din[5]
    - clr_flag_A pulses if din[4]
    - enable_irq_B <= din[3]
    - enable_irq_A <= din[2]
    - load_B <= din[1]
    - load_A <= din[0]
- Latency: all register outputs and clr pulses update on the clk edge that samples the first strobe cycle. Each clr pulse is high for exactly one clk. Loads are levels; the timer's load-rising edge performs the reload.
- Busy counter: decrements by 1 on each cen while non-zero. busy = (counter != 0). Simultaneous data write and cen: the reload wins.
- dout: registered every clk from the current busy, flag_B and flag_A, so it has one clk of latency.
- csm_keyon: pulses high for one clk when ch3_mode==2'b10 && cen && zero && load_A && overflow_A. This is the same qualifier the timer uses to set flag_A. ch3_mode 2'b01 and 2'b11 never produce key-on.
- Reset mid-busy: busy clears immediately. Reset mid-strobe: a strobe still held low after reset does not count as a new write.

Decomposition:
- Shared package/header holds:
  - register addresses REG_TIMA_HI=8'h24, REG_TIMA_LO=8'h25, REG_TIMB=8'h26, REG_TMODE=8'h27;
  - 0x27 bit positions (LOAD_A=0, LOAD_B=1, EN_A=2, EN_B=3, CLR_A=4, CLR_B=5, MODE_LSB=6);
  - CSM mode code 2'b10.
- One sub-module: jt12_busy_cnt (load, cen-gated down-count, busy output).

Test Plan:
- Write addr 0x24 / data 0xFF, then addr 0x25 / data 0x03 -> value_A=10'h3FF one clk after each data strobe; busy high for 32 cen ticks after the last write, then 0.
- Write 0x26=0x80, then 0x27=0x3F -> value_B=0x80; load_A=load_B=1; enable_irq_A=enable_irq_B=1; clr_flag_A and clr_flag_B each high exactly 1 clk; ch3_mode=0.
- With address latched via addr=2'b10 (part 1) then data 0x55 to reg 0x24 -> value_A unchanged, busy still asserted.
- 0x27=0x81, then drive overflow_A=1 with cen=zero=1 for one clk -> csm_keyon=1 for that clk. Repeat with 0x27=0x41 -> csm_keyon stays 0.
- Hold cs_n=wr_n=0 for 10 clks on a 0x27=0x10 data write -> clr_flag_A pulses once. Assert rst_n=0 while busy=1 -> busy=0 and dout=0 on the next edge.
- flag_A=1, flag_B=1 while busy -> dout=8'h83 one clk later. After busy expires -> dout=8'h03.
